mem_tile_net_responder: RTL
===========================

// Module: mem_tile_net_responder
// PURPOSE
// Tile-side endpoint of the on-chip memory network. Sits between a router local port and one L2/SRF
// memory tile bank. Accepts request flits, assembles multi-flit wide (256b) SRF writes, issues one
// access to the bank, then returns read data as response flits to the requesting core.
// Handles one transaction at a time.
// PARAMETERS
// ADDR_WIDTH    32   request address width
// WIDE_WIDTH    256  bank line / SRF wide channel width (bits)
// FLIT_SIZE     64   flit data width (bits); BEATS = WIDE_WIDTH/FLIT_SIZE = 4
// CORE_ID_W     2    src_core field width
// PORTS
// clk           in   1             clock
// rst_n         in   1             asynchronous active-low reset
// srf_mode      in   1             morph_config.srf_enable; wide transfers are honoured only when 1
// net_req_in    in   1             request flit valid from router local port
// net_flit_in   in   generic_flit_t request flit (addr,is_read,is_wide,transfer_type,payload_size,data,last_flit,ipriority,src_core)
// net_ack_out   out  1             flit consumed this cycle
// net_req_out   out  1             response flit valid to router local port
// net_flit_out  out  generic_flit_t response flit
// net_ack_in    in   1             router accepted response flit
// mem_req       out  1             bank access request; held until mem_gnt
// mem_we        out  1             1=write, 0=read
// mem_addr      out  ADDR_WIDTH    line address; bits [4:0] forced to 0
// mem_wdata     out  WIDE_WIDTH    write line
// mem_be        out  WIDE_WIDTH/8  byte enables
// mem_gnt       in   1             bank accepted request
// mem_rvalid    in   1             read line valid (one cycle, any cycle after gnt)
// mem_rdata     in   WIDE_WIDTH    read line
// busy          out  1             state != IDLE
// err_cnt       out  8             saturating protocol-error counter
// BEHAVIOUR
// Reset: all outputs 0, FSM IDLE, beat counter 0, assembly buffer cleared, err_cnt 0.
// Input handshake: flit transfers when net_req_in && net_ack_out. net_ack_out=net_req_in only in IDLE/COLLECT.
// Output handshake: net_req_out/net_flit_out stable until net_ack_in; transfer on req&&ack.
// Wide flag: eff_wide = flit.is_wide && srf_mode; is_wide with srf_mode=0 -> treated narrow, err_cnt++.
// FSM:
//  IDLE: on accepted flit, latch addr/is_read/eff_wide/transfer_type/ipriority/src_core.
//   narrow or read: -> MEM_REQ (narrow write data placed in beat addr[4:3], be = 8 bytes of that beat).
//   wide write: store data in beat 0, beat_cnt=1; last_flit ? MEM_REQ : COLLECT.
//  COLLECT: each accepted flit -> beat[beat_cnt], be for that beat set, beat_cnt++. last_flit -> MEM_REQ.
//   Flits beyond 4 before last_flit: data dropped, err_cnt++ once per packet. Early last_flit: missing beats be=0.
//  MEM_REQ: mem_req=1 (next cycle after entry); on mem_gnt: write -> IDLE (no response), read -> MEM_WAIT.
//  MEM_WAIT: on mem_rvalid capture mem_rdata -> RESP; beat_cnt=0.
//  RESP: narrow read: one flit, data = rdata beat addr[4:3], payload_size 8, last_flit=1.
//   wide read: 4 flits beat 0..3, addr = line+8*beat, payload_size 32, last_flit on beat 3.
//   All response flits: is_read=0, is_wide/transfer_type/ipriority/src_core echoed. After final ack -> IDLE.
// Latency (gnt same cycle, rvalid next): narrow read flit accept cycle 0 -> mem_req cycle 1 -> rvalid cycle 2
//  -> net_req_out cycle 3. Zero-stall wide read: 4 response flits cycles 3..6.
// mem_rvalid outside MEM_WAIT ignored, err_cnt++. err_cnt saturates at 255.
// Reset mid-transaction: asynchronously abandons packet; no partial write issued, no response sent.
// STRUCTURE
// Shared package (trips_types): generic_flit_t, resp_state_e {IDLE,COLLECT,MEM_REQ,MEM_WAIT,RESP},
//  constants BEATS, NARROW_BYTES=8, WIDE_BYTES=32.
// One sub-module natural: wide_beat_buffer (4x64b assembly/disassembly with per-beat byte enables,
//  write-by-index, read-by-index, clear); FSM and handshakes stay in the top.
// TESTING
// Narrow read addr 0x108, src_core=2, rdata beat1=0xDEAD_BEEF_0000_0001 -> one flit, data matches, src_core=2, last=1, cycle 3.
// Wide write srf_mode=1, 4 flits 0x11..,0x22..,0x33..,0x44.., last on 4th -> one mem write, be all 1s, wdata = concat.
// Wide write, last_flit on 2nd flit -> be[15:0]=1s, be[31:16]=0; 6-flit packet -> 4 beats written, err_cnt=1.
// Wide read srf_mode=0 with is_wide=1 -> single narrow response, err_cnt=1.
// Wide read, net_ack_in held low 5 cycles on beat 2 -> flit stable, no beat skipped/duplicated, addrs +0x8 step.
// rst_n asserted in COLLECT after 2 beats -> outputs 0 immediately, no mem_req after release; next packet normal.

Source files
------------

// File: rtl/mem_tile_net_responder_pkg.sv
// Shared types and constants for the memory-tile network responder: flit layout,
// FSM states, beat geometry and the saturating error-counter helper.
package mem_tile_net_responder_pkg;
  localparam int ADDR_WIDTH   = 32;
  localparam int WIDE_WIDTH   = 256;
  localparam int FLIT_SIZE    = 64;
  localparam int CORE_ID_W    = 2;
  localparam int BEATS        = WIDE_WIDTH / FLIT_SIZE;
  localparam int NARROW_BYTES = 8;
  localparam int WIDE_BYTES   = 32;
  localparam int BE_W         = WIDE_WIDTH / 8;
  localparam int BEAT_IDX_W   = 2;
  localparam int BEAT_CNT_W   = 3;
  localparam int LINE_OFF_W   = 5;
  localparam int BEAT_LSB     = 3;

  localparam logic [BEAT_CNT_W-1:0] BEAT_FULL = BEAT_CNT_W'(BEATS);
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  is_read;
    logic                  is_wide;
    logic [1:0]            transfer_type;
    logic [7:0]            payload_size;
    logic [FLIT_SIZE-1:0]  data;
    logic                  last_flit;
    logic [1:0]            ipriority;
    logic [CORE_ID_W-1:0]  src_core;
  } generic_flit_t;

  typedef enum logic [2:0] {IDLE, COLLECT, MEM_REQ, MEM_WAIT, RESP} resp_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
endpackage

// File: rtl/mem_tile_net_responder_if.sv
// Router local-port and bank-side bus bundle; slave is the responder's view.
interface mem_tile_net_responder_if;
  import mem_tile_net_responder_pkg::*;

  logic                  net_req_in;
  generic_flit_t         net_flit_in;
  logic                  net_ack_out;
  logic                  net_req_out;
  generic_flit_t         net_flit_out;
  logic                  net_ack_in;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDE_WIDTH-1:0] mem_wdata;
  logic [BE_W-1:0]       mem_be;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [WIDE_WIDTH-1:0] mem_rdata;

  modport slave (
    input  net_req_in, net_flit_in, net_ack_in, mem_gnt, mem_rvalid, mem_rdata,
    output net_ack_out, net_req_out, net_flit_out, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output net_req_in, net_flit_in, net_ack_in, mem_gnt, mem_rvalid, mem_rdata,
    input  net_ack_out, net_req_out, net_flit_out, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_tile_net_responder_wide_beat_buffer.sv
// 4 x 64b line buffer: assembles write beats with per-beat byte enables and
// holds a captured read line for beat-by-beat disassembly.
module mem_tile_net_responder_wide_beat_buffer
  import mem_tile_net_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [BEAT_IDX_W-1:0] wr_idx,
  input  logic [FLIT_SIZE-1:0]  wr_data,
  input  logic                  load_en,
  input  logic [WIDE_WIDTH-1:0] load_line,
  input  logic [BEAT_IDX_W-1:0] rd_idx,
  output logic [FLIT_SIZE-1:0]  rd_data,
  output logic [WIDE_WIDTH-1:0] line_out,
  output logic [BE_W-1:0]       be_out
);
  logic [BEATS-1:0][FLIT_SIZE-1:0]    beat_q, beat_d;
  logic [BEATS-1:0][NARROW_BYTES-1:0] be_q, be_d;

  // Clear then write in the same cycle so a new packet's first beat lands in a clean line.
  always_comb begin
    beat_d = beat_q;
    be_d   = be_q;
    if (clr) begin
      beat_d = '0;
      be_d   = '0;
    end
    if (load_en) beat_d = load_line;
    if (wr_en) begin
      beat_d[wr_idx] = wr_data;
      be_d[wr_idx]   = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      be_q   <= '0;
    end else begin
      beat_q <= beat_d;
      be_q   <= be_d;
    end
  end

  assign rd_data  = beat_q[rd_idx];
  assign line_out = beat_q;
  assign be_out   = be_q;
endmodule

// File: rtl/mem_tile_net_responder.sv
// Tile-side network endpoint: collects request flits, issues one bank access per
// packet and returns read data as response flits. One transaction in flight.
module mem_tile_net_responder
  import mem_tile_net_responder_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    srf_mode,
  mem_tile_net_responder_if.slave bus,
  output logic                    busy,
  output logic [7:0]              err_cnt
);
  resp_state_e           state_q, state_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  is_read_q, is_read_d;
  logic                  wide_q, wide_d;
  logic                  drop_q, drop_d;
  logic [1:0]            ttype_q, ttype_d;
  logic [1:0]            prio_q, prio_d;
  logic [CORE_ID_W-1:0]  src_q, src_d;
  logic [7:0]            err_q, err_d;
  logic [1:0]            err_inc;

  logic                  accept, eff_wide;
  logic                  buf_clr, buf_wr, buf_load;
  logic [BEAT_IDX_W-1:0] buf_wr_idx, buf_rd_idx;
  logic [FLIT_SIZE-1:0]  buf_rd_data;
  logic [WIDE_WIDTH-1:0] buf_line;
  logic [BE_W-1:0]       buf_be;
  generic_flit_t         rsp;
  logic [7:0]            unused_payload_size;

  assign unused_payload_size = bus.net_flit_in.payload_size;
  assign bus.net_ack_out = bus.net_req_in && (state_q == IDLE || state_q == COLLECT);
  assign accept          = bus.net_req_in && bus.net_ack_out;
  assign eff_wide        = bus.net_flit_in.is_wide && srf_mode;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    is_read_d  = is_read_q;
    wide_d     = wide_q;
    drop_d     = drop_q;
    ttype_d    = ttype_q;
    prio_d     = prio_q;
    src_d      = src_q;
    err_inc    = 2'd0;
    buf_clr    = 1'b0;
    buf_wr     = 1'b0;
    buf_wr_idx = '0;
    buf_load   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d     = bus.net_flit_in.addr;
          is_read_d  = bus.net_flit_in.is_read;
          wide_d     = eff_wide;
          ttype_d    = bus.net_flit_in.transfer_type;
          prio_d     = bus.net_flit_in.ipriority;
          src_d      = bus.net_flit_in.src_core;
          drop_d     = 1'b0;
          beat_cnt_d = '0;
          buf_clr    = 1'b1;
          if (bus.net_flit_in.is_wide && !srf_mode) err_inc = err_inc + 2'd1;
          if (!bus.net_flit_in.is_read) begin
            buf_wr     = 1'b1;
            buf_wr_idx = eff_wide ? '0 : bus.net_flit_in.addr[LINE_OFF_W-1:BEAT_LSB];
          end
          if (eff_wide && !bus.net_flit_in.is_read) begin
            beat_cnt_d = BEAT_CNT_W'(1);
            state_d    = bus.net_flit_in.last_flit ? MEM_REQ : COLLECT;
          end else begin
            state_d = MEM_REQ;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          // Beats past the line are still consumed so the router drains the packet.
          if (beat_cnt_q < BEAT_FULL) begin
            buf_wr     = 1'b1;
            buf_wr_idx = beat_cnt_q[BEAT_IDX_W-1:0];
            beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
          end else if (!drop_q) begin
            drop_d  = 1'b1;
            err_inc = err_inc + 2'd1;
          end
          if (bus.net_flit_in.last_flit) state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (bus.mem_gnt) state_d = is_read_q ? MEM_WAIT : IDLE;
      end
      MEM_WAIT: begin
        if (bus.mem_rvalid) begin
          buf_load   = 1'b1;
          beat_cnt_d = '0;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.net_ack_in) begin
          if (!wide_q || beat_cnt_q[BEAT_IDX_W-1:0] == LAST_BEAT) state_d = IDLE;
          else beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.mem_rvalid && state_q != MEM_WAIT) err_inc = err_inc + 2'd1;
  end

  assign err_d = sat_add8(err_q, err_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      is_read_q  <= 1'b0;
      wide_q     <= 1'b0;
      drop_q     <= 1'b0;
      ttype_q    <= '0;
      prio_q     <= '0;
      src_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      is_read_q  <= is_read_d;
      wide_q     <= wide_d;
      drop_q     <= drop_d;
      ttype_q    <= ttype_d;
      prio_q     <= prio_d;
      src_q      <= src_d;
      err_q      <= err_d;
    end
  end

  assign buf_rd_idx = wide_q ? beat_cnt_q[BEAT_IDX_W-1:0] : addr_q[LINE_OFF_W-1:BEAT_LSB];

  mem_tile_net_responder_wide_beat_buffer u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (buf_clr),
    .wr_en    (buf_wr),
    .wr_idx   (buf_wr_idx),
    .wr_data  (bus.net_flit_in.data),
    .load_en  (buf_load),
    .load_line(bus.mem_rdata),
    .rd_idx   (buf_rd_idx),
    .rd_data  (buf_rd_data),
    .line_out (buf_line),
    .be_out   (buf_be)
  );

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (state_q == MEM_REQ) begin
      bus.mem_req  = 1'b1;
      bus.mem_we   = !is_read_q;
      bus.mem_addr = {addr_q[ADDR_WIDTH-1:LINE_OFF_W], LINE_OFF_W'(0)};
      if (!is_read_q) begin
        bus.mem_wdata = buf_line;
        bus.mem_be    = buf_be;
      end
    end
  end

  // Response flit is built purely from registered state, so it holds until acked.
  always_comb begin
    rsp = '0;
    if (state_q == RESP) begin
      rsp.addr          = wide_q ? {addr_q[ADDR_WIDTH-1:LINE_OFF_W], beat_cnt_q[BEAT_IDX_W-1:0],
                                    BEAT_LSB'(0)} : addr_q;
      rsp.is_read       = 1'b0;
      rsp.is_wide       = wide_q;
      rsp.transfer_type = ttype_q;
      rsp.payload_size  = wide_q ? 8'(WIDE_BYTES) : 8'(NARROW_BYTES);
      rsp.data          = buf_rd_data;
      rsp.last_flit     = !wide_q || beat_cnt_q[BEAT_IDX_W-1:0] == LAST_BEAT;
      rsp.ipriority     = prio_q;
      rsp.src_core      = src_q;
    end
    bus.net_req_out  = (state_q == RESP);
    bus.net_flit_out = rsp;
  end

  assign busy    = (state_q != IDLE);
  assign err_cnt = err_q;
endmodule
